// File: rtl/truth_table_scanner.sv
// Sequential truth-table reader: walks every input vector of an external
// combinational function, builds its minterm mask, counts the ones and compares.
module truth_table_scanner #(
  parameter int N      = 3,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             f_in,
  input  logic [2**N-1:0]  exp_mask,
  output logic [N-1:0]     vec_out,
  output logic             busy,
  output logic             done,
  output logic [2**N-1:0]  minterms,
  output logic [N:0]       ones,
  output logic             match
);

  localparam int M  = 2**N;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [N-1:0]  LAST_VEC  = '1;
  localparam logic [SW-1:0] SCNT_LAST = SW'(SETTLE - 1);

  logic [1:0]    state;
  logic [SW-1:0] scnt;
  logic [M-1:0]  mask_next;

  // Mask with the current sample merged in, so the final compare sees the last bit.
  always_comb begin
    mask_next          = minterms;
    mask_next[vec_out] = f_in;
  end

  assign busy = (state == WAIT) || (state == SAMPLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      vec_out  <= '0;
      minterms <= '0;
      ones     <= '0;
      match    <= 1'b0;
      scnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= WAIT;
            vec_out  <= '0;
            minterms <= '0;
            ones     <= '0;
            match    <= 1'b0;
            scnt     <= '0;
          end
        end
        WAIT: begin
          scnt <= scnt + 1'b1;
          if (scnt == SCNT_LAST) state <= SAMPLE;
        end
        SAMPLE: begin
          minterms <= mask_next;
          ones     <= ones + {{N{1'b0}}, f_in};
          if (vec_out == LAST_VEC) begin
            state <= DONE;
            match <= (mask_next == exp_mask);
          end else begin
            vec_out <= vec_out + 1'b1;
            scnt    <= '0;
            state   <= WAIT;
          end
        end
        DONE: begin
          vec_out <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (SETTLE=1 and SETTLE=3) checked
// every cycle against a timing model derived from edges-since-start arithmetic.
`timescale 1ns/1ps
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  start;
  logic [1:0]  f_in;
  logic [7:0]  exp_mask;
  int unsigned fsel;

  logic [2:0]  vec  [2];
  logic [7:0]  mint [2];
  logic [3:0]  ones [2];
  logic [1:0]  busy, done, match;

  int n_vec = 0;
  int n_bad = 0;

  // 0: (x|~y)&(~y|~z)   1: constant 0   2: constant 1   3: x^y^z
  function automatic logic feval(input int unsigned sel, input logic [2:0] v);
    logic x, y, z;
    {x, y, z} = v;
    case (sel)
      0:       return (x | ~y) & (~y | ~z);
      1:       return 1'b0;
      2:       return 1'b1;
      default: return x ^ y ^ z;
    endcase
  endfunction

  assign f_in[0] = feval(fsel, vec[0]);
  assign f_in[1] = feval(fsel, vec[1]);

  truth_table_scanner #(.N(3), .SETTLE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .f_in(f_in[0]),
    .exp_mask(exp_mask), .vec_out(vec[0]), .busy(busy[0]), .done(done[0]),
    .minterms(mint[0]), .ones(ones[0]), .match(match[0])
  );

  truth_table_scanner #(.N(3), .SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .f_in(f_in[1]),
    .exp_mask(exp_mask), .vec_out(vec[1]), .busy(busy[1]), .done(done[1]),
    .minterms(mint[1]), .ones(ones[1]), .match(match[1])
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: t = edges since the accepting edge; vector v is sampled at edge (v+1)*(S+1).
  bit         m_act   [2];
  int         m_t     [2];
  logic [7:0] m_truth [2];
  logic [7:0] m_mint  [2];
  logic [3:0] m_ones  [2];
  logic [2:0] m_vec   [2];
  logic       m_busy  [2];
  logic       m_done  [2];
  logic       m_match [2];

  always @(posedge clk or negedge rst_n) begin
    int s, len, c;
    for (int i = 0; i < 2; i++) begin
      s   = (i == 0) ? 1 : 3;
      len = 8 * (s + 1);
      if (!rst_n) begin
        m_act[i] = 1'b0; m_t[i] = 0; m_mint[i] = '0; m_ones[i] = '0;
        m_vec[i] = '0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_match[i] = 1'b0;
      end else if (!m_act[i]) begin
        m_done[i] = 1'b0;
        m_busy[i] = 1'b0;
        m_vec[i]  = '0;
        if (start[i]) begin
          m_act[i] = 1'b1; m_t[i] = 0;
          for (int v = 0; v < 8; v++) m_truth[i][v] = feval(fsel, 3'(v));
          m_mint[i] = '0; m_ones[i] = '0; m_match[i] = 1'b0; m_busy[i] = 1'b1;
        end
      end else begin
        m_t[i]++;
        if (m_t[i] < len) begin
          c         = m_t[i] / (s + 1);
          m_vec[i]  = 3'(c);
          m_mint[i] = m_truth[i] & 8'((1 << c) - 1);
          m_ones[i] = 4'($countones(m_mint[i]));
        end else if (m_t[i] == len) begin
          m_mint[i]  = m_truth[i];
          m_ones[i]  = 4'($countones(m_truth[i]));
          m_match[i] = (m_truth[i] == exp_mask);
          m_done[i]  = 1'b1;
          m_busy[i]  = 1'b0;
        end else begin
          m_act[i]  = 1'b0;
          m_done[i] = 1'b0;
          m_vec[i]  = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d vec_out", i),  vec[i],   m_vec[i]);
      check($sformatf("u%0d busy", i),     busy[i],  m_busy[i]);
      check($sformatf("u%0d done", i),     done[i],  m_done[i]);
      check($sformatf("u%0d minterms", i), mint[i],  m_mint[i]);
      check($sformatf("u%0d ones", i),     ones[i],  m_ones[i]);
      check($sformatf("u%0d match", i),    match[i], m_match[i]);
    end
  end

  task automatic run_scan(input int i, output int edges);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    edges = 0;
    while (done[i] !== 1'b1 && edges < 200) begin
      @(negedge clk);
      edges++;
    end
  endtask

  initial begin
    int edges, k, ndone;
    rst_n = 1'b0; start = '0; fsel = 0; exp_mask = 8'h73;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 2'b00);
    check("reset vec", vec[0], 3'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // f=(x|~y)&(~y|~z), expected mask agrees
    run_scan(0, edges);
    check("t1 latency", 16'(edges), 16'd16);
    check("t1 minterms", mint[0], 8'h73);
    check("t1 ones", ones[0], 4'd5);
    check("t1 match", match[0], 1'b1);
    repeat (3) @(negedge clk);

    // expected mask disagrees; results must hold
    exp_mask = 8'h72;
    run_scan(0, edges);
    check("t2 minterms", mint[0], 8'h73);
    check("t2 match", match[0], 1'b0);
    repeat (20) @(negedge clk);
    check("t2 held minterms", mint[0], 8'h73);
    check("t2 held ones", ones[0], 4'd5);
    check("t2 held match", match[0], 1'b0);

    // constant functions
    fsel = 1; exp_mask = 8'h00;
    run_scan(0, edges);
    check("t3 f0 minterms", mint[0], 8'h00);
    check("t3 f0 ones", ones[0], 4'd0);
    check("t3 f0 match", match[0], 1'b1);
    fsel = 2; exp_mask = 8'hFF;
    run_scan(0, edges);
    check("t3 f1 minterms", mint[0], 8'hFF);
    check("t3 f1 ones", ones[0], 4'd8);
    repeat (3) @(negedge clk);

    // xor on the SETTLE=3 instance
    fsel = 3; exp_mask = 8'h96;
    run_scan(1, edges);
    check("t4 latency", 16'(edges), 16'd32);
    check("t4 minterms", mint[1], 8'h96);
    check("t4 ones", ones[1], 4'd4);
    check("t4 match", match[1], 1'b1);
    repeat (3) @(negedge clk);

    // second start during vector 3 is ignored
    fsel = 0; exp_mask = 8'h73;
    start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    k = 0;
    while (vec[0] !== 3'd3 && k < 50) begin @(negedge clk); k++; end
    check("t5 reached vec3", vec[0], 3'd3);
    start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    ndone = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (done[0] === 1'b1) ndone++;
    end
    check("t5 done count", 16'(ndone), 16'd1);
    check("t5 minterms", mint[0], 8'h73);
    check("t5 ones", ones[0], 4'd5);
    check("t5 match", match[0], 1'b1);

    // reset at vector 5 aborts the scan
    start[0] = 1'b1; @(negedge clk); start[0] = 1'b0;
    k = 0;
    while (vec[0] !== 3'd5 && k < 50) begin @(negedge clk); k++; end
    check("t6 reached vec5", vec[0], 3'd5);
    #2 rst_n = 1'b0;
    #1;
    check("t6 rst vec", vec[0], 3'd0);
    check("t6 rst busy", busy[0], 1'b0);
    check("t6 rst minterms", mint[0], 8'h00);
    check("t6 rst ones", ones[0], 4'd0);
    check("t6 rst done", done[0], 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_scan(0, edges);
    check("t6 latency", 16'(edges), 16'd16);
    check("t6 minterms", mint[0], 8'h73);
    check("t6 match", match[0], 1'b1);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
